spawn_queue: RTL and testbench

SPAWN_QUEUE -- requirements
Module: spawn_queue

---
 rtl/spawn_queue.sv | 118 +++++++++++
 tb/tb_spawn_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_queue.sv
// spawn_queue: circular slot allocator for spawned entities. Control (clk, rst, start, crash, restart, update, enable), spawn inputs (rng_data, speed_ok), per-slot status (slot_visible, slot_remove, slot_x_end, slot_gap), slot outputs (slot_update, slot_start, slot_type), queue status (front, count, full, empty).
module spawn_queue #(
  parameter int SLOTS = 7,
  parameter int TYPES = 3,
  parameter int MAX_DUP = 2,
  parameter int GAME_WIDTH = 640,
  localparam int IW = $clog2(SLOTS),
  localparam int CW = $clog2(SLOTS + 1),
  localparam int TW = $clog2(TYPES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          crash,
  input  logic                          restart,
  input  logic                          update,
  input  logic                          enable,
  input  logic [10:0]                   rng_data,
  input  logic [TYPES-1:0]              speed_ok,
  input  logic [SLOTS-1:0]              slot_visible,
  input  logic [SLOTS-1:0]              slot_remove,
  input  logic [SLOTS-1:0][11:0]        slot_x_end,
  input  logic [SLOTS-1:0][10:0]        slot_gap,
  output logic                          slot_update,
  output logic [SLOTS-1:0]              slot_start,
  output logic [SLOTS-1:0][TW-1:0]      slot_type,
  output logic [IW-1:0]                 front,
  output logic [CW-1:0]                 count,
  output logic                          full,
  output logic                          empty
);
  typedef enum logic [2:0] {IDLE, RUN, SPAWN, SETTLE, RETIRE, HALT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] back, last;
  logic spawn_en, retire_en, found, dup, do_spawn, do_retire;
  logic [TW-1:0] pick, cand;
  logic [TYPES:0] ok_ext;
  logic signed [12:0] edge_sum;
  function automatic logic [IW-1:0] sub_wrap(input logic [IW-1:0] a, input int n);
    return IW'((int'(a) + SLOTS - n) % SLOTS);
  endfunction
  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] a);
    return (a == IW'(SLOTS - 1)) ? '0 : a + IW'(1);
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = crash ? HALT : update ? SPAWN : RUN;
      SPAWN:   state_nx = SETTLE;
      SETTLE:  state_nx = RETIRE;
      RETIRE:  state_nx = RUN;
      default: state_nx = HALT;
    endcase
    if (restart) state_nx = IDLE;
  end
  always_comb begin
    spawn_en = state == SPAWN;
    retire_en = state == RETIRE;
  end
  assign full = count == CW'(SLOTS);
  assign empty = count == '0;
  assign last = sub_wrap(back, 1);
  assign ok_ext = {speed_ok, 1'b0};
  // type code 0 is NONE, so a shifted copy lets the candidate code index speed_ok directly
  always_comb begin
    pick = '0;
    found = 1'b0;
    cand = '0;
    dup = 1'b0;
    for (int i = 0; i < TYPES; i++) begin
      cand = TW'((int'(rng_data) + i) % TYPES + 1);
      dup = count >= CW'(MAX_DUP);
      for (int j = 1; j <= MAX_DUP; j++) dup = dup && slot_type[sub_wrap(back, j)] == cand;
      if (!found && ok_ext[cand] && !dup) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  // sign-extend the edge to 13 bits so a partly off-screen entity still compares correctly
  assign edge_sum = {slot_x_end[last][11], slot_x_end[last]} + {2'b00, slot_gap[last]};
  assign do_spawn = !full && enable && found &&
                    (empty || (slot_start[last] && slot_visible[last] && edge_sum < $signed(13'(GAME_WIDTH))));
  assign do_retire = !empty && slot_start[front] && slot_remove[front];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      front <= '0;
      back <= '0;
      count <= '0;
      slot_start <= '0;
      slot_type <= '0;
      slot_update <= 1'b0;
    end else if (restart) begin
      front <= '0;
      back <= '0;
      count <= '0;
      slot_start <= '0;
      slot_type <= '0;
      slot_update <= 1'b0;
    end else begin
      slot_update <= spawn_en;
      if (spawn_en && do_spawn) begin
        slot_type[back] <= pick;
        slot_start[back] <= 1'b1;
        back <= inc_wrap(back);
        count <= count + CW'(1);
      end
      if (retire_en && do_retire) begin
        slot_start[front] <= 1'b0;
        front <= inc_wrap(front);
        count <= count - CW'(1);
      end
    end
endmodule

// File: tb/tb_spawn_queue.sv
// tb_spawn_queue: directed self-checking bench for spawn_queue (default build plus a SLOTS=5 build).
module tb_spawn_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, crash = 1'b0, restart = 1'b0, update = 1'b0, enable = 1'b0;
  logic [10:0] rng = '0;
  logic [2:0] speed_ok = 3'b111;
  logic [6:0] visible = '0, remove = '0;
  logic [6:0][11:0] x_end;
  logic [6:0][10:0] gap;
  logic slot_update, full, empty;
  logic [6:0] slot_start;
  logic [6:0][1:0] slot_type;
  logic [2:0] front, count;
  logic start5 = 1'b0, update5 = 1'b0;
  logic [10:0] rng5 = '0;
  logic [4:0] remove5 = '0;
  logic [4:0][11:0] x_end5 = '0;
  logic [4:0][10:0] gap5 = '0;
  logic slot_update5, full5, empty5;
  logic [4:0] slot_start5, mask;
  logic [4:0][1:0] slot_type5;
  logic [2:0] front5, count5;
  int checks = 0, errors = 0, f, c;
  always #5 clk = ~clk;
  spawn_queue u_dut (
    .clk(clk), .rst(rst), .start(start), .crash(crash), .restart(restart), .update(update),
    .enable(enable), .rng_data(rng), .speed_ok(speed_ok), .slot_visible(visible),
    .slot_remove(remove), .slot_x_end(x_end), .slot_gap(gap), .slot_update(slot_update),
    .slot_start(slot_start), .slot_type(slot_type), .front(front), .count(count),
    .full(full), .empty(empty)
  );
  spawn_queue #(.SLOTS(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .crash(1'b0), .restart(1'b0), .update(update5),
    .enable(1'b1), .rng_data(rng5), .speed_ok(3'b111), .slot_visible(5'b11111),
    .slot_remove(remove5), .slot_x_end(x_end5), .slot_gap(gap5), .slot_update(slot_update5),
    .slot_start(slot_start5), .slot_type(slot_type5), .front(front5), .count(count5),
    .full(full5), .empty(empty5)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frame();
    update = 1'b1;
    tick();
    update = 1'b0;
    repeat (3) tick();
  endtask
  task automatic frame5();
    update5 = 1'b1;
    tick();
    update5 = 1'b0;
    repeat (3) tick();
  endtask
  initial begin
    for (int i = 0; i < 7; i++) begin
      x_end[i] = 12'd100;
      gap[i] = 11'd0;
    end
    #1;
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_start", slot_start, 0);
    chk("rst_update", slot_update, 0);
    chk("rst_type", slot_type, 0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    update = 1'b1;
    tick();
    update = 1'b0;
    chk("upd_lat1", slot_update, 0);
    tick();
    chk("upd_lat2", slot_update, 1);
    chk("first_start", slot_start, 7'b0000001);
    chk("first_type", slot_type[0], 1);
    chk("first_count", count, 1);
    tick();
    chk("upd_clear", slot_update, 0);
    tick();
    visible = '1;
    rng = 11'd1;
    frame();
    chk("f1_type", slot_type[1], 2);
    frame();
    chk("f2_type", slot_type[2], 2);
    chk("f2_count", count, 3);
    speed_ok = 3'b010;
    frame();
    chk("dup_block_count", count, 3);
    chk("dup_block_start", slot_start, 7'b0000111);
    speed_ok = 3'b111;
    frame();
    chk("dup_alt_type", slot_type[3], 3);
    chk("dup_alt_count", count, 4);
    x_end[3] = 12'd500;
    gap[3] = 11'd140;
    frame();
    chk("gap140_count", count, 4);
    gap[3] = 11'd139;
    frame();
    chk("gap139_count", count, 5);
    chk("gap139_type", slot_type[4], 2);
    x_end[4] = 12'hfec;
    gap[4] = 11'd0;
    frame();
    chk("neg_edge_count", count, 6);
    frame();
    chk("fill_type", slot_type[6], 3);
    chk("fill_full", full, 1);
    frame();
    chk("full_nospawn", count, 7);
    chk("full_start", slot_start, 7'b1111111);
    enable = 1'b0;
    remove = '1;
    repeat (6) frame();
    chk("ret_front6", front, 6);
    chk("ret_count1", count, 1);
    chk("ret_start", slot_start, 7'b1000000);
    frame();
    chk("ret_wrap_front", front, 0);
    chk("ret_empty", empty, 1);
    frame();
    chk("nonlive_count", count, 0);
    chk("nonlive_front", front, 0);
    remove = '0;
    enable = 1'b1;
    rng = 11'd2;
    frame();
    chk("back_wrap_start", slot_start, 7'b0000001);
    chk("back_wrap_type", slot_type[0], 3);
    chk("back_wrap_count", count, 1);
    update = 1'b1;
    repeat (3) tick();
    update = 1'b0;
    tick();
    chk("drop_count", count, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drop_noupd", slot_update, 0);
    end
    chk("drop_count2", count, 2);
    crash = 1'b1;
    update = 1'b1;
    tick();
    crash = 1'b0;
    update = 1'b0;
    tick();
    chk("crash_noupd", slot_update, 0);
    frame();
    chk("halt_count", count, 2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_count", count, 0);
    chk("restart_start", slot_start, 0);
    chk("restart_empty", empty, 1);
    chk("restart_type", slot_type, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    frame();
    chk("restart_spawn", slot_start, 7'b0000001);
    update = 1'b1;
    tick();
    update = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst_count", count, 0);
    chk("async_rst_start", slot_start, 0);
    tick();
    rst = 1'b0;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    f = 0;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      rng5 = 11'(i);
      frame5();
      if (c < 5) c++;
      chk("s5_fill_count", count5, 32'(c));
    end
    chk("s5_full", full5, 1);
    remove5 = '1;
    for (int i = 0; i < 12; i++) begin
      rng5 = 11'(i + 3);
      frame5();
      if (c < 5) c++;
      if (c > 0) begin
        c--;
        f = (f + 1) % 5;
      end
      mask = '0;
      for (int k = 0; k < c; k++) mask[(f + k) % 5] = 1'b1;
      chk("s5_front", front5, 32'(f));
      chk("s5_count", count5, 32'(c));
      chk("s5_mask", slot_start5, 32'(mask));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
